serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one soma1bit cell, one bit per clock, LSB first.
// Also holds the soma1bit full-adder cell so the block stays self-contained.

module soma1bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Only the upper WIDTH-1 result bits need storage; the last bit comes from the cell.
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;

  logic             cell_s, cell_c;
  logic [WIDTH-1:0] res_next;

  soma1bit u_cell (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .s     (cell_s),
    .c_out (cell_c)
  );

  assign res_next = {cell_s, res_q};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = res_next[WIDTH-1:1];
        carry_d = cell_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          sum_d   = res_next;
          c_out_d = cell_c;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=2.

module tb_serial_add_ctrl;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       c_in;
  logic       busy, done;
  logic [7:0] sum;
  logic       c_out;

  logic       start2;
  logic [1:0] a2, b2;
  logic       c_in2;
  logic       busy2, done2;
  logic [1:0] sum2;
  logic       c_out2;

  int n_checks;
  int n_fail;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .c_in  (c_in2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .c_out (c_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start one WIDTH=8 operation (DUT must be able to accept) and check its result.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input string tag);
    logic [8:0] exp;
    logic [7:0] held;
    int n;
    bit busy_ok, stable_ok;
    exp = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
    a = av; b = bv; c_in = cv; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
    held = sum;
    n = 0; busy_ok = 1; stable_ok = 1;
    while (!done && n < 20) begin
      if (!busy) busy_ok = 0;
      if (sum !== held) stable_ok = 0;
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 8);
    check({tag, "_busy"}, {31'd0, busy_ok}, 1);
    check({tag, "_hold"}, {31'd0, stable_ok}, 1);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp[7:0]});
    check({tag, "_cout"}, {31'd0, c_out}, {31'd0, exp[8]});
    check({tag, "_nobusy"}, {31'd0, busy}, 0);
  endtask

  logic [7:0] bb_a [4] = '{8'h12, 8'h80, 8'h7F, 8'hC3};
  logic [7:0] bb_b [4] = '{8'h34, 8'h80, 8'h01, 8'h3C};
  logic       bb_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [8:0] bb_e [4] = '{9'h046, 9'h101, 9'h080, 9'h100};

  initial begin
    int n, seen;
    logic [8:0] e9;
    logic [2:0] e3;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout", {31'd0, c_out}, 0);
    rst_n = 1'b1;

    op8(8'h5A, 8'h3C, 1'b0, "t5a3c");
    tick();
    op8(8'hFF, 8'h01, 1'b0, "tff01");
    op8(8'hFF, 8'hFF, 1'b1, "tffff");
    op8(8'h00, 8'h00, 1'b1, "t0001");
    tick();

    // Second start mid-RUN must be ignored.
    a = 8'h10; b = 8'h01; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen++;
        check("ign_sum", {24'd0, sum}, 32'h11);
        check("ign_cout", {31'd0, c_out}, 0);
      end
      tick();
    end
    check("ign_ndone", seen, 1);

    // Back-to-back with start held high.
    a = bb_a[0]; b = bb_b[0]; c_in = bb_c[0]; start = 1'b1;
    tick();
    a = bb_a[1]; b = bb_b[1]; c_in = bb_c[1];
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      check("b2b_lat", n, 8);
      check("b2b_sum", {24'd0, sum}, {24'd0, bb_e[i][7:0]});
      check("b2b_cout", {31'd0, c_out}, {31'd0, bb_e[i][8]});
      if (i == 3) start = 1'b0;
      tick();
      if (i < 2) begin
        a = bb_a[i+2]; b = bb_b[i+2]; c_in = bb_c[i+2];
      end
    end
    tick();
    check("b2b_idle", {31'd0, busy | done}, 0);

    // Async reset at cnt=4 discards the operation.
    a = 8'h33; b = 8'h44; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", {24'd0, sum}, 0);
    check("mid_rst_cout", {31'd0, c_out}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, done}, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen++;
      tick();
    end
    check("mid_rst_nodone", seen, 0);
    op8(8'h01, 8'h02, 1'b0, "post_rst");

    // Random regression, WIDTH=8.
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      op8(8'($urandom), 8'($urandom), 1'($urandom), "rnd8");
    end

    // Random regression, WIDTH=2.
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      a2 = 2'($urandom); b2 = 2'($urandom); c_in2 = 1'($urandom);
      e3 = {1'b0, a2} + {1'b0, b2} + {2'd0, c_in2};
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      a2 = 2'($urandom); b2 = 2'($urandom);
      n = 0;
      while (!done2 && n < 10) begin
        tick();
        n++;
      end
      check("rnd2_lat", n, 2);
      check("rnd2_res", {29'd0, c_out2, sum2}, {29'd0, e3});
    end

    e9 = '0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
